// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width default, port indices and output-controller states.
package noc_pkg;

  localparam int unsigned FlitWDefault = 32;
  localparam int          NumPorts     = 5;

  typedef enum logic [2:0] {
    PortN = 3'd0,
    PortS = 3'd1,
    PortW = 3'd2,
    PortE = 3'd3,
    PortL = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StXfer    = 2'd1,
    StRelease = 2'd2
  } oc_state_e;

  localparam logic [NumPorts-1:0] OneVec = NumPorts'(1);

  // One-hot mask selecting a single port.
  function automatic logic [NumPorts-1:0] port_bit(input port_e p);
    return OneVec << p;
  endfunction

  // True when zero or one bit of v is set.
  function automatic logic at_most_one(input logic [NumPorts-1:0] v);
    return (v & (v - OneVec)) == '0;
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry output register for one link, with valid/ready handshake.
module flit_out_reg
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = FlitWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [FLIT_W-1:0] load_flit,
  input  logic              load_tail,
  input  logic              ready,
  output logic [FLIT_W-1:0] flit,
  output logic              tail,
  output logic              valid,
  output logic              free
);

  logic [FLIT_W-1:0] flit_q;
  logic              tail_q;
  logic              valid_q;

  // The entry can take a new flit when empty or being drained this cycle.
  assign free = !valid_q || ready;

  // Load on request (only issued while free), otherwise drain on ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_q  <= '0;
      tail_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      flit_q  <= load_flit;
      tail_q  <= load_tail;
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign flit  = flit_q;
  assign tail  = tail_q;
  assign valid = valid_q;

endmodule

// File: rtl/e_output_ctrl.sv
// East output controller: locks the east link to one granted input for a whole packet.
module e_output_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W = FlitWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rrp_e_priority_n_i,
  input  logic              rrp_e_priority_s_i,
  input  logic              rrp_e_priority_w_i,
  input  logic              rrp_e_priority_e_i,
  input  logic              rrp_e_priority_l_i,
  input  logic [FLIT_W-1:0] n_flit_i,
  input  logic [FLIT_W-1:0] s_flit_i,
  input  logic [FLIT_W-1:0] w_flit_i,
  input  logic [FLIT_W-1:0] l_flit_i,
  input  logic              n_valid_i,
  input  logic              s_valid_i,
  input  logic              w_valid_i,
  input  logic              l_valid_i,
  input  logic              n_tail_i,
  input  logic              s_tail_i,
  input  logic              w_tail_i,
  input  logic              l_tail_i,
  output logic              n_pop_o,
  output logic              s_pop_o,
  output logic              w_pop_o,
  output logic              l_pop_o,
  output logic [FLIT_W-1:0] e_flit_o,
  output logic              e_valid_o,
  output logic              e_tail_o,
  input  logic              e_ready_i,
  output logic              rr_register_change_order_o,
  output logic              err_o
);

  logic [NumPorts-1:0] grant, nswl_grant, in_valid, in_tail, pop_vec;
  logic [FLIT_W-1:0]   in_flit [NumPorts];
  logic [FLIT_W-1:0]   pop_flit;
  logic                pop_any, pop_tail, or_free, change_order;
  logic                grant_illegal, grant_legal;
  oc_state_e           state_q, state_d;
  logic [NumPorts-1:0] owner_q, owner_d;
  logic                err_q, err_d;

  assign grant[PortN] = rrp_e_priority_n_i;
  assign grant[PortS] = rrp_e_priority_s_i;
  assign grant[PortW] = rrp_e_priority_w_i;
  assign grant[PortE] = rrp_e_priority_e_i;
  assign grant[PortL] = rrp_e_priority_l_i;

  // The east port never feeds its own output, so its input slot is tied off.
  assign in_valid[PortN] = n_valid_i;
  assign in_valid[PortS] = s_valid_i;
  assign in_valid[PortW] = w_valid_i;
  assign in_valid[PortE] = 1'b0;
  assign in_valid[PortL] = l_valid_i;

  assign in_tail[PortN] = n_tail_i;
  assign in_tail[PortS] = s_tail_i;
  assign in_tail[PortW] = w_tail_i;
  assign in_tail[PortE] = 1'b0;
  assign in_tail[PortL] = l_tail_i;

  assign in_flit[PortN] = n_flit_i;
  assign in_flit[PortS] = s_flit_i;
  assign in_flit[PortW] = w_flit_i;
  assign in_flit[PortE] = '0;
  assign in_flit[PortL] = l_flit_i;

  assign nswl_grant    = grant & ~port_bit(PortE);
  assign grant_illegal = grant[PortE] || !at_most_one(nswl_grant);
  assign grant_legal   = !grant_illegal && (nswl_grant != '0) && ((nswl_grant & in_valid) != '0);

  // Output decode: pops and the change-order pulse, all suppressed during reset.
  always_comb begin
    pop_vec      = '0;
    change_order = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle:    if (grant_legal && or_free) pop_vec = nswl_grant;
        StXfer:    pop_vec = owner_q & in_valid & {NumPorts{or_free}};
        StRelease: change_order = 1'b1;
        default:   ;
      endcase
    end
  end

  // Steer the popped input's flit and tail into the output register.
  always_comb begin
    pop_flit = '0;
    pop_tail = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (pop_vec[i]) begin
        pop_flit = pop_flit | in_flit[i];
        pop_tail = pop_tail | in_tail[i];
      end
    end
  end

  assign pop_any = |pop_vec;

  // Next-state: lock the owner on the head pop, release after the tail pop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (grant_illegal) err_d = 1'b1;
        if (pop_any) begin
          owner_d = pop_vec;
          state_d = pop_tail ? StRelease : StXfer;
        end
      end
      StXfer: begin
        if (pop_any && pop_tail) state_d = StRelease;
      end
      StRelease: begin
        owner_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, owner and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  flit_out_reg #(
    .FLIT_W(FLIT_W)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pop_any),
    .load_flit(pop_flit),
    .load_tail(pop_tail),
    .ready    (e_ready_i),
    .flit     (e_flit_o),
    .tail     (e_tail_o),
    .valid    (e_valid_o),
    .free     (or_free)
  );

  assign n_pop_o = pop_vec[PortN];
  assign s_pop_o = pop_vec[PortS];
  assign w_pop_o = pop_vec[PortW];
  assign l_pop_o = pop_vec[PortL];

  assign rr_register_change_order_o = change_order;
  assign err_o                      = err_q;

endmodule

// File: tb/tb_e_output_ctrl.sv
// Bench for e_output_ctrl: input buffers modelled as queues, packet-level scoreboard on the link.
module tb_e_output_ctrl;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    gnt;      // {l, e, w, s, n}
  logic [3:0]    vin, tin; // {l, w, s, n}
  logic [FW-1:0] fin [4];
  logic [3:0]    pops;
  logic [FW-1:0] e_flit;
  logic          e_valid, e_tail, rdy, co, err;

  always #5 clk = ~clk;

  e_output_ctrl #(.FLIT_W(FW)) dut (
    .clk(clk), .reset(reset),
    .rrp_e_priority_n_i(gnt[0]), .rrp_e_priority_s_i(gnt[1]), .rrp_e_priority_w_i(gnt[2]),
    .rrp_e_priority_e_i(gnt[3]), .rrp_e_priority_l_i(gnt[4]),
    .n_flit_i(fin[0]), .s_flit_i(fin[1]), .w_flit_i(fin[2]), .l_flit_i(fin[3]),
    .n_valid_i(vin[0]), .s_valid_i(vin[1]), .w_valid_i(vin[2]), .l_valid_i(vin[3]),
    .n_tail_i(tin[0]), .s_tail_i(tin[1]), .w_tail_i(tin[2]), .l_tail_i(tin[3]),
    .n_pop_o(pops[0]), .s_pop_o(pops[1]), .w_pop_o(pops[2]), .l_pop_o(pops[3]),
    .e_flit_o(e_flit), .e_valid_o(e_valid), .e_tail_o(e_tail), .e_ready_i(rdy),
    .rr_register_change_order_o(co), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  // Input buffers and the packets queued in them, per port (0 n, 1 s, 2 w, 3 l).
  logic [FW-1:0] qf [4][$];
  logic          qt [4][$];
  int            pk_id [4][$];
  int            pk_len [4][$];
  int            next_id = 1;
  int            last_id;

  // Scoreboard state for the packet currently on the link.
  int            cur_p, cur_id, cur_idx, cur_len, done_pkts, co_count;
  logic          stall_prev, prev_co, stall_tail;
  logic [FW-1:0] stall_flit;

  // Snapshot of the last sampled cycle.
  logic [3:0]    s_pop;
  logic          s_ev, s_et, s_co, s_err, s_rdy;
  logic [FW-1:0] s_ef;

  typedef struct {
    logic [4:0] gnt;
    logic [3:0] vin;
    logic [3:0] exp_pop;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_flit(input int p, input int id, input int idx);
    return {4'(p + 1), 12'(id), 16'(idx)};
  endfunction

  function automatic logic [4:0] pb(input int p);
    logic [4:0] r;
    r = '0;
    r[(p == 3) ? 4 : p] = 1'b1;
    return r;
  endfunction

  task automatic update_drive();
    for (int p = 0; p < 4; p++) begin
      vin[p] = (qf[p].size() != 0);
      fin[p] = vin[p] ? qf[p][0] : '0;
      tin[p] = vin[p] ? qt[p][0] : 1'b0;
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    last_id = next_id++;
    for (int i = 0; i < len; i++) begin
      qf[p].push_back(make_flit(p, last_id, i));
      qt[p].push_back(i == len - 1);
    end
    pk_id[p].push_back(last_id);
    pk_len[p].push_back(len);
    update_drive();
  endtask

  task automatic sb_clear();
    for (int p = 0; p < 4; p++) begin
      qf[p].delete(); qt[p].delete(); pk_id[p].delete(); pk_len[p].delete();
    end
    cur_p = -1; done_pkts = 0; co_count = 0; stall_prev = 1'b0; prev_co = 1'b0;
    update_drive();
  endtask

  // A flit accepted on the link must be the next flit of the packet in flight,
  // or the head of some port's oldest undelivered packet.
  task automatic score(input logic [FW-1:0] f, input logic t);
    int p;
    if (cur_p < 0) begin
      p = int'(f[31:28]) - 1;
      if (p < 0 || p > 3 || pk_id[p].size() == 0) begin
        chk("unexpected_flit", f, 0);
        return;
      end
      cur_p = p; cur_id = pk_id[p].pop_front(); cur_len = pk_len[p].pop_front(); cur_idx = 0;
    end
    chk("flit_data", f, make_flit(cur_p, cur_id, cur_idx));
    chk("flit_tail", t, (cur_idx == cur_len - 1));
    cur_idx++;
    if (cur_idx >= cur_len) begin
      cur_p = -1;
      done_pkts++;
    end
  endtask

  // One clock: sample just after the negedge, check, then apply pops after the posedge.
  task automatic cycle();
    logic rst_now;
    #1;
    s_pop = pops; s_ev = e_valid; s_ef = e_flit; s_et = e_tail;
    s_co = co; s_err = err; s_rdy = rdy; rst_now = reset;
    chk("pop_at_most_one", ($countones(s_pop) <= 1), 1);
    if (stall_prev) begin
      chk("stall_valid", s_ev, 1);
      chk("stall_flit", s_ef, stall_flit);
      chk("stall_tail", s_et, stall_tail);
    end
    stall_prev = s_ev && !s_rdy && !rst_now;
    stall_flit = s_ef;
    stall_tail = s_et;
    if (s_co) begin
      co_count++;
      chk("co_single_cycle", prev_co, 0);
    end
    prev_co = s_co;
    if (s_ev && s_rdy && !rst_now) score(s_ef, s_et);
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (s_pop[p]) begin
        chk("pop_nonempty", (qf[p].size() != 0), 1);
        if (qf[p].size() != 0) begin
          void'(qf[p].pop_front());
          void'(qt[p].pop_front());
        end
      end
    end
    update_drive();
    @(negedge clk);
  endtask

  task automatic drain();
    int idle;
    idle = 0;
    rdy = 1'b1;
    for (int k = 0; k < 300 && idle < 3; k++) begin
      gnt = '0;
      for (int p = 3; p >= 0; p--) if (qf[p].size() != 0) gnt = pb(p);
      cycle();
      if (vin == 4'b0 && !s_ev) idle++;
      else idle = 0;
    end
    gnt = '0;
    chk("drain_done", (idle >= 3), 1);
    chk("drain_no_partial", cur_p, -1);
    chk("co_per_packet", co_count, done_pkts);
  endtask

  task automatic do_reset();
    gnt = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    sb_clear();
  endtask

  task automatic t_table();
    vec_t tbl[12];
    tbl[0]  = '{5'b00001, 4'b1111, 4'b0001};
    tbl[1]  = '{5'b00010, 4'b0010, 4'b0010};
    tbl[2]  = '{5'b00100, 4'b1011, 4'b0000};
    tbl[3]  = '{5'b10000, 4'b1000, 4'b1000};
    tbl[4]  = '{5'b00101, 4'b1111, 4'b0000};
    tbl[5]  = '{5'b01000, 4'b1111, 4'b0000};
    tbl[6]  = '{5'b01001, 4'b1111, 4'b0000};
    tbl[7]  = '{5'b00000, 4'b1111, 4'b0000};
    tbl[8]  = '{5'b10000, 4'b0001, 4'b0000};
    tbl[9]  = '{5'b00100, 4'b0100, 4'b0100};
    tbl[10] = '{5'b11000, 4'b1111, 4'b0000};
    tbl[11] = '{5'b10010, 4'b1111, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      gnt = tbl[i].gnt;
      vin = tbl[i].vin;
      #1;
      chk($sformatf("table%0d_pop", i), pops, tbl[i].exp_pop);
      // Withdraw before the edge so the FSM stays idle between vectors.
      gnt = '0;
      update_drive();
      @(negedge clk);
    end
    chk("table_no_err", err, 0);
  endtask

  task automatic t_three_flit();
    int e_pop[5] = '{1, 1, 1, 0, 0};
    int e_ev[5]  = '{0, 1, 1, 1, 0};
    int e_co[5]  = '{0, 0, 0, 1, 0};
    sb_clear();
    add_pkt(0, 3);
    rdy = 1'b1;
    gnt = pb(0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      gnt = '0;
      chk($sformatf("n3_pop_c%0d", k), s_pop, e_pop[k]);
      chk($sformatf("n3_valid_c%0d", k), s_ev, e_ev[k]);
      chk($sformatf("n3_co_c%0d", k), s_co, e_co[k]);
      if (s_ev) chk($sformatf("n3_tail_c%0d", k), s_et, (k == 3));
    end
    drain();
    chk("n3_delivered", done_pkts, 1);
  endtask

  task automatic t_single_flit();
    sb_clear();
    add_pkt(3, 1);
    rdy = 1'b1;
    gnt = pb(3);
    cycle();
    chk("l1_pop", s_pop, 4'b1000);
    chk("l1_valid_c0", s_ev, 0);
    gnt = '0;
    add_pkt(3, 1);
    cycle();
    chk("l1_release_no_pop", s_pop, 0);
    chk("l1_valid_c1", s_ev, 1);
    chk("l1_tail_c1", s_et, 1);
    chk("l1_co_c1", s_co, 1);
    gnt = pb(3);
    cycle();
    chk("l1_idle_again_pop", s_pop, 4'b1000);
    chk("l1_co_c2", s_co, 0);
    gnt = '0;
    drain();
    chk("l1_delivered", done_pkts, 2);
  endtask

  task automatic t_backpressure();
    logic [FW-1:0] held;
    sb_clear();
    add_pkt(1, 5);
    rdy = 1'b1;
    gnt = pb(1);
    cycle();
    gnt = '0;
    cycle();
    rdy = 1'b0;
    cycle();
    held = s_ef;
    chk("bp_pop_c0", s_pop[1], 0);
    chk("bp_valid", s_ev, 1);
    for (int k = 1; k < 4; k++) begin
      cycle();
      chk($sformatf("bp_pop_c%0d", k), s_pop[1], 0);
      chk($sformatf("bp_hold_c%0d", k), s_ef, held);
    end
    drain();
    chk("bp_delivered", done_pkts, 1);
  endtask

  task automatic t_grant_switch();
    logic [3:0] e_pop[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
    sb_clear();
    add_pkt(2, 3);
    add_pkt(1, 2);
    rdy = 1'b1;
    gnt = pb(2);
    for (int k = 0; k < 5; k++) begin
      cycle();
      gnt = pb(1);
      chk($sformatf("sw_pop_c%0d", k), s_pop, e_pop[k]);
    end
    gnt = '0;
    drain();
    chk("sw_delivered", done_pkts, 2);
  endtask

  task automatic t_mid_reset();
    sb_clear();
    add_pkt(0, 4);
    rdy = 1'b1;
    gnt = pb(0);
    cycle();
    gnt = '0;
    cycle();
    rdy = 1'b0;
    cycle();
    chk("mr_held_valid", s_ev, 1);
    chk("mr_held_flit", s_ef, make_flit(0, last_id, 1));
    reset = 1'b1;
    cycle();
    chk("mr_reset_no_pop", s_pop, 0);
    chk("mr_reset_no_co", s_co, 0);
    reset = 1'b0;
    cycle();
    chk("mr_after_valid", s_ev, 0);
    chk("mr_after_co", s_co, 0);
    sb_clear();
    rdy = 1'b1;
    add_pkt(0, 1);
    gnt = pb(0);
    cycle();
    chk("mr_idle_pop", s_pop, 4'b0001);
    chk("mr_no_co_late", s_co, 0);
    gnt = '0;
    drain();
  endtask

  task automatic t_illegal();
    do_reset();
    add_pkt(0, 2);
    add_pkt(2, 2);
    rdy = 1'b1;
    gnt = pb(0) | pb(2);
    cycle();
    chk("ill2_no_pop", s_pop, 0);
    chk("ill2_err_before", s_err, 0);
    gnt = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("ill2_err_sticky%0d", k), s_err, 1);
    end
    do_reset();
    chk("ill2_err_cleared", err, 0);
    add_pkt(0, 1);
    gnt = 5'b01000;
    cycle();
    chk("ille_no_pop", s_pop, 0);
    gnt = '0;
    cycle();
    chk("ille_err", s_err, 1);
    do_reset();
    chk("ille_err_cleared", err, 0);
  endtask

  task automatic t_random();
    int p, r;
    sb_clear();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 3);
        if (qf[p].size() < 12) add_pkt(p, $urandom_range(1, 4));
      end
      r = $urandom_range(0, 5);
      gnt = (r < 4) ? pb(r) : 5'b0;
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    chk("rand_no_err", s_err, 0);
    chk("rand_traffic", (done_pkts > 20), 1);
  endtask

  initial begin
    reset = 1'b1;
    gnt   = '0;
    rdy   = 1'b0;
    sb_clear();
    @(negedge clk);
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_valid", s_ev, 0);
    chk("rst_tail", s_et, 0);
    chk("rst_flit", s_ef, 0);
    chk("rst_err", s_err, 0);
    chk("rst_co", s_co, 0);
    chk("rst_pop", s_pop, 0);
    t_table();
    t_three_flit();
    t_single_flit();
    t_backpressure();
    t_grant_switch();
    t_random();
    t_mid_reset();
    t_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
